serial_deserializer: RTL and testbench
======================================

# serial_deserializer

Serial-to-parallel capture stage that sits directly downstream of the synchronous D flip-flop. It consumes the registered single-bit stream the flip-flop produces and assembles it MSB-first into WIDTH-bit words. An optional even-parity bit follows each word. Each completed word is presented with a one-cycle valid strobe and a parity-error flag.

## Interface
- WIDTH, 8: data bits per word; legal range 2..32.
- PARITY_EN, 1: 1 means one even-parity bit follows each word; 0 means no parity bit.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit (the flip-flop's q).
- din_valid  input  1  qualifies din; a bit is consumed only on an edge where this is 1.
- clear  input  1  synchronous abort of the word in progress.
- data_out  output  WIDTH  last completed word; holds until the next completion.
- data_valid  output  1  one-cycle strobe marking a new data_out.
- parity_err  output  1  parity result for the current data_out; meaningful while data_valid is 1 and held afterwards.
- busy  output  1  high while a word is partially received.

## Operation
- Internal state: shift register sr[WIDTH-1:0], bit counter cnt (0..WIDTH), and state machine {SHIFT, PAR}.
- SHIFT state, on an edge with din_valid=1:
  - sr <= {sr[WIDTH-2:0], din}; cnt <= cnt+1.
  - When cnt reaches WIDTH-1 (the last data bit is being taken) and PARITY_EN=1: go to PAR.
  - Same condition with PARITY_EN=0: complete the word from {sr[WIDTH-2:0], din}, set parity_err=0, cnt <= 0, stay in SHIFT.
- PAR state, on an edge with din_valid=1:
  - din is the parity bit.
  - Complete the word: data_out <= sr; parity_err <= ^sr ^ din (nonzero means an error).
  - cnt <= 0; go to SHIFT.
- din_valid=0: all state holds. Gaps of any length between bits are legal.
- Word completion: data_out and parity_err update, and data_valid=1 for exactly one cycle.
- On every edge where no completion occurs, data_valid=0.
- busy = (cnt != 0) or (state == PAR).
- clear=1 on an edge:
  - state <= SHIFT, cnt <= 0, sr <= 0, data_valid <= 0.
  - data_out and parity_err hold their values.
  - clear has priority over din_valid on the same edge; that edge's bit is discarded.
- reset=1 (asynchronous, any time, including mid-word):
  - data_out=0, data_valid=0, parity_err=0, busy=0.
  - sr=0, cnt=0, state=SHIFT.
  - The partial word is lost. Reception restarts at bit 0 on the first valid bit after reset deasserts.

## Timing
- Every input is sampled on the rising edge of clk. All outputs are registered.
- Latency: data_valid rises at the same edge that samples the final bit (the parity bit, or data bit WIDTH-1 when PARITY_EN=0). It falls at the next edge.
- Back-to-back words need no idle cycle.
  - The first bit of word N+1 may arrive on the edge right after word N completes.
  - data_valid therefore pulses once per word with no merging.
- Minimum word period: WIDTH+PARITY_EN cycles.
- One bit per edge at most. There is no backpressure: the consumer must take data_out during the data_valid cycle or before the next completion.

## Test plan
- Reset-value check:
  - Stimulus: assert reset mid-cycle with clk running and din toggling.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - Required: after deassertion, busy stays 0 until the first din_valid.
- Golden word (WIDTH=8, PARITY_EN=1):
  - Stimulus: bits 1,0,1,0,0,1,0,1 then parity 0 on 9 consecutive valid edges.
  - Required: data_out=8'hA5, parity_err=0, data_valid high for exactly one cycle after the 9th edge, busy high after edges 1-8.
- Parity error:
  - Stimulus: 8'h3C with parity bit 1.
  - Required: data_out=8'h3C, parity_err=1.
  - Then send 8'h01 with parity 1. Required: parity_err=0.
- Gapped plus back-to-back:
  - Stimulus: 8'hA5 with din_valid low for 3 cycles between each bit, immediately followed by 8'hFF with parity 0 on consecutive edges.
  - Required: two separate data_valid pulses carrying 8'hA5 and then 8'hFF, with parity_err=0 for both.
- Clear and reset mid-word:
  - Stimulus: 5 bits of a word, then clear=1 together with din_valid=1, then a full 8'h5A word.
  - Required: no data_valid from the aborted word, and data_out=8'h5A.
  - Repeat the same sequence with reset pulsed after 5 bits instead of clear. Required: same result.
- PARITY_EN=0, WIDTH=4:
  - Stimulus: bits 1,1,0,1 then 0,0,1,0.
  - Required: data_out=4'hD and then 4'h2, one data_valid pulse per word, parity_err always 0.

Source files
------------

// File: rtl/serial_deserializer.sv
// Serial-to-parallel capture: assembles an MSB-first bit stream into WIDTH-bit
// words, optionally followed by an even-parity bit, with a one-cycle valid strobe.
module serial_deserializer #(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {SHIFT, PAR} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] data_out_n;
    logic             data_valid_n, parity_err_n, busy_n;
    logic [WIDTH-1:0] shifted;

    assign shifted = {sr[WIDTH-2:0], din};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SHIFT;
        else       state <= state_n;
    end

    always_comb begin
        state_n      = state;
        sr_n         = sr;
        cnt_n        = cnt;
        data_out_n   = data_out;
        data_valid_n = 1'b0;
        parity_err_n = parity_err;
        // clear wins over a coincident bit; that bit is dropped
        if (clear) begin
            state_n = SHIFT;
            cnt_n   = '0;
            sr_n    = '0;
        end else if (din_valid) begin
            case (state)
                SHIFT: begin
                    sr_n  = shifted;
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        if (PARITY_EN != 0) begin
                            state_n = PAR;
                        end else begin
                            data_out_n   = shifted;
                            parity_err_n = 1'b0;
                            data_valid_n = 1'b1;
                            cnt_n        = '0;
                        end
                    end
                end
                PAR: begin
                    data_out_n   = sr;
                    parity_err_n = ^sr ^ din;
                    data_valid_n = 1'b1;
                    cnt_n        = '0;
                    state_n      = SHIFT;
                end
                default: state_n = SHIFT;
            endcase
        end
        busy_n = (cnt_n != '0) || (state_n == PAR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr         <= '0;
            cnt        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sr         <= sr_n;
            cnt        <= cnt_n;
            data_out   <= data_out_n;
            data_valid <= data_valid_n;
            parity_err <= parity_err_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: WIDTH=8 with parity and WIDTH=4 without.
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] data_out8;
    logic       data_valid8, parity_err8, busy8;
    logic [3:0] data_out4;
    logic       data_valid4, parity_err4, busy4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_deserializer #(.WIDTH(8), .PARITY_EN(1)) dut8 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
        .data_out(data_out8), .data_valid(data_valid8), .parity_err(parity_err8), .busy(busy8)
    );

    serial_deserializer #(.WIDTH(4), .PARITY_EN(0)) dut4 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
        .data_out(data_out4), .data_valid(data_valid4), .parity_err(parity_err4), .busy(busy4)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic [7:0] exp_data;
        logic       exp_perr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One valid bit on the next edge; returns 1 time unit after that edge.
    task automatic send_bit(input logic b);
        din = b;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            din = ~din;
            @(posedge clk);
            #1;
        end
    endtask

    // Data bits with busy/no-strobe checks, then the parity bit and strobe checks.
    task automatic word8(input string tag, input logic [7:0] d, input logic p, input int gap,
                         input logic [7:0] exp_d, input logic exp_pe);
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i]);
            chk({tag, " busy"}, busy8, 1'b1);
            chk({tag, " no strobe"}, data_valid8, 1'b0);
            if (gap > 0) begin
                idle(gap);
                chk({tag, " busy in gap"}, busy8, 1'b1);
            end
        end
        send_bit(p);
        chk({tag, " valid"}, data_valid8, 1'b1);
        chk({tag, " data"}, data_out8, exp_d);
        chk({tag, " perr"}, parity_err8, exp_pe);
        chk({tag, " busy done"}, busy8, 1'b0);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 8'h3C, 1'b1};
        tbl[2] = '{8'h01, 1'b1, 8'h01, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
        tbl[4] = '{8'h5A, 1'b1, 8'h5A, 1'b1};
        tbl[5] = '{8'h80, 1'b0, 8'h80, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset data_out", data_out8, 8'h00);
        chk("reset busy", busy8, 1'b0);
        reset = 1'b0;
        idle(2);
        chk("idle busy", busy8, 1'b0);

        // Table: consecutive words, strobe must drop on the edge after each completion.
        for (int k = 0; k < 6; k++) begin
            word8($sformatf("vec%0d", k), tbl[k].data, tbl[k].par, 0, tbl[k].exp_data, tbl[k].exp_perr);
            idle(1);
            chk($sformatf("vec%0d strobe drop", k), data_valid8, 1'b0);
            chk($sformatf("vec%0d data hold", k), data_out8, tbl[k].exp_data);
        end

        // Asynchronous reset mid-cycle, mid-word (parity_err is 1 from last vector).
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        reset = 1'b1;
        din = ~din;
        #1;
        chk("async rst data_out", data_out8, 8'h00);
        chk("async rst perr", parity_err8, 1'b0);
        chk("async rst busy", busy8, 1'b0);
        chk("async rst valid", data_valid8, 1'b0);
        #3;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);
        chk("post rst busy", busy8, 1'b0);

        // Gapped A5 then back-to-back FF.
        word8("gapA5", 8'hA5, 1'b0, 3, 8'hA5, 1'b0);
        word8("b2bFF", 8'hFF, 1'b0, 0, 8'hFF, 1'b0);
        idle(1);
        chk("b2b strobe drop", data_valid8, 1'b0);

        // Clear mid-word with a coincident valid bit.
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        din = 1'b1;
        din_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        din_valid = 1'b0;
        chk("clear busy", busy8, 1'b0);
        chk("clear valid", data_valid8, 1'b0);
        chk("clear data hold", data_out8, 8'hFF);
        word8("clr5A", 8'h5A, 1'b0, 0, 8'h5A, 1'b0);

        // Same with a reset pulse instead of clear.
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        chk("rst pulse busy", busy8, 1'b0);
        word8("rst5A", 8'h5A, 1'b0, 0, 8'h5A, 1'b0);

        // WIDTH=4, no parity.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("w4 busy", busy4, 1'b1);
        chk("w4 no strobe", data_valid4, 1'b0);
        send_bit(1'b1);
        chk("w4 D valid", data_valid4, 1'b1);
        chk("w4 D data", data_out4, 4'hD);
        chk("w4 D perr", parity_err4, 1'b0);
        send_bit(1'b0);
        chk("w4 b2b drop", data_valid4, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("w4 no strobe2", data_valid4, 1'b0);
        send_bit(1'b0);
        chk("w4 2 valid", data_valid4, 1'b1);
        chk("w4 2 data", data_out4, 4'h2);
        chk("w4 2 perr", parity_err4, 1'b0);
        chk("w4 2 busy", busy4, 1'b0);
        idle(1);
        chk("w4 strobe drop", data_valid4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
